vga_game_ctrl: RTL



---
 rtl/vga_game_pkg.sv | 27 ++
 rtl/aabb_overlap.sv | 32 +++
 rtl/vga_game_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/vga_game_pkg.sv
// Geometry, widths and state encoding shared by the game controller and the VGA bit generator.
package vga_game_pkg;

   localparam int unsigned COORD_W   = 10;
   localparam int unsigned SCORE_W   = 16;

   localparam int unsigned PLAYER_W  = 40;
   localparam int unsigned PLAYER_H  = 40;
   localparam int unsigned OBS_W     = 20;
   localparam int unsigned OBS_H     = 80;
   localparam int unsigned H_VISIBLE = 640;
   localparam int unsigned V_VISIBLE = 480;

   typedef logic [COORD_W-1:0] coord_t;
   typedef logic [SCORE_W-1:0] score_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_OVER = 2'd2
   } game_state_e;

   function automatic coord_t to_coord(input int unsigned value);
      return coord_t'(value);
   endfunction

endpackage

// File: rtl/aabb_overlap.sv
// Combinational half-open rectangle intersection test; sums are one bit wider so edges never wrap.
module aabb_overlap
   import vga_game_pkg::*;
(
   input  coord_t a_x_i,
   input  coord_t a_y_i,
   input  coord_t a_w_i,
   input  coord_t a_h_i,
   input  coord_t b_x_i,
   input  coord_t b_y_i,
   input  coord_t b_w_i,
   input  coord_t b_h_i,
   output logic   overlap_o
);

   logic [COORD_W:0] a_left, a_top, a_right, a_bottom;
   logic [COORD_W:0] b_left, b_top, b_right, b_bottom;

   assign a_left   = {1'b0, a_x_i};
   assign a_top    = {1'b0, a_y_i};
   assign a_right  = {1'b0, a_x_i} + {1'b0, a_w_i};
   assign a_bottom = {1'b0, a_y_i} + {1'b0, a_h_i};

   assign b_left   = {1'b0, b_x_i};
   assign b_top    = {1'b0, b_y_i};
   assign b_right  = {1'b0, b_x_i} + {1'b0, b_w_i};
   assign b_bottom = {1'b0, b_y_i} + {1'b0, b_h_i};

   assign overlap_o = (a_left < b_right) && (b_left < a_right) &&
                      (a_top < b_bottom) && (b_top < a_bottom);

endmodule

// File: rtl/vga_game_ctrl.sv
// Per-frame game step: player jump physics, scrolling obstacle, collision, score and game state.
// Every output comes straight from a flop and only moves in the cycle after frame_tick.
module vga_game_ctrl
   import vga_game_pkg::*;
#(
   parameter int unsigned PLAYER_X  = 80,
   parameter int unsigned GROUND_Y  = 400,
   parameter int unsigned JUMP_V    = 16,
   parameter int unsigned GRAVITY   = 1,
   parameter int unsigned OBS_SPEED = 4,
   parameter int unsigned SCREEN_W  = H_VISIBLE
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         frame_tick,
   input  logic         jump_btn,
   input  logic         start_btn,
   output logic [9:0]   player_x,
   output logic [9:0]   player_y,
   output logic [9:0]   obs_x,
   output logic [9:0]   obs_y,
   output logic [15:0]  score,
   output logic         game_over,
   output logic         running
);

   localparam coord_t PLAYER_X_C  = to_coord(PLAYER_X);
   localparam coord_t GROUND_TOP  = to_coord(GROUND_Y - PLAYER_H);
   localparam coord_t OBS_TOP     = to_coord(GROUND_Y - OBS_H);
   localparam coord_t OBS_SPEED_C = to_coord(OBS_SPEED);
   localparam coord_t SCREEN_W_C  = to_coord(SCREEN_W);

   localparam logic signed [5:0]         JUMP_S       = 6'(JUMP_V);
   localparam logic signed [5:0]         GRAVITY_S    = 6'(GRAVITY);
   localparam logic signed [COORD_W:0]   GROUND_TOP_S = (COORD_W+1)'(GROUND_Y - PLAYER_H);

   game_state_e        state_q, state_d;
   coord_t             player_x_q;
   coord_t             player_y_q, player_y_d;
   coord_t             obs_x_q, obs_x_d;
   coord_t             obs_y_q;
   logic signed [5:0]  vy_q, vy_d;
   score_t             score_q, score_d;
   logic               jump_req_q, jump_req_d;
   logic               jump_btn_q;
   logic               game_over_q, game_over_d;
   logic               running_q, running_d;

   logic                       jump_rise;
   logic                       jump_now;
   logic                       grounded;
   logic                       hit;
   logic signed [5:0]          vy_eff;
   logic signed [5:0]          vy_step;
   logic signed [COORD_W:0]    y_step;
   coord_t                     y_new;
   logic signed [5:0]          vy_new;

   aabb_overlap u_hit (
      .a_x_i     (player_x_q),
      .a_y_i     (player_y_q),
      .a_w_i     (to_coord(PLAYER_W)),
      .a_h_i     (to_coord(PLAYER_H)),
      .b_x_i     (obs_x_q),
      .b_y_i     (obs_y_q),
      .b_w_i     (to_coord(OBS_W)),
      .b_h_i     (to_coord(OBS_H)),
      .overlap_o (hit)
   );

   // An edge arriving in the same cycle as the tick still counts for that tick.
   assign jump_rise = jump_btn && !jump_btn_q;
   assign jump_now  = jump_req_q || jump_rise;
   assign grounded  = (player_y_q == GROUND_TOP) && (vy_q == 6'sd0);

   always_comb begin
      vy_eff  = (grounded && jump_now) ? -JUMP_S : vy_q;
      y_step  = $signed({1'b0, player_y_q}) + $signed({{(COORD_W-5){vy_eff[5]}}, vy_eff});
      vy_step = vy_eff + GRAVITY_S;
      if (y_step >= GROUND_TOP_S) begin
         y_new  = GROUND_TOP;
         vy_new = 6'sd0;
      end else begin
         y_new  = y_step[COORD_W-1:0];
         vy_new = vy_step;
      end
   end

   // NOTE: every _d gets a default before the case so no path can leave one unassigned (no latches).
   always_comb begin
      state_d    = state_q;
      player_y_d = player_y_q;
      obs_x_d    = obs_x_q;
      vy_d       = vy_q;
      score_d    = score_q;
      jump_req_d = frame_tick ? 1'b0 : jump_now;

      case (state_q)
         ST_IDLE: begin
            if (frame_tick && start_btn) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (frame_tick) begin
               if (hit) begin
                  state_d = ST_OVER;
               end else begin
                  player_y_d = y_new;
                  vy_d       = vy_new;
                  if (obs_x_q < OBS_SPEED_C) begin
                     obs_x_d = SCREEN_W_C;
                     score_d = score_q + score_t'(1);
                  end else begin
                     obs_x_d = obs_x_q - OBS_SPEED_C;
                  end
               end
            end
         end
         ST_OVER: begin
            if (frame_tick && start_btn) begin
               state_d    = ST_RUN;
               player_y_d = GROUND_TOP;
               obs_x_d    = SCREEN_W_C;
               vy_d       = 6'sd0;
               score_d    = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      game_over_d = (state_d == ST_OVER);
      running_d   = (state_d == ST_RUN);
   end

   // NOTE: state lives in flops updated with <= so all registers sample the same pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         player_x_q  <= PLAYER_X_C;
         player_y_q  <= GROUND_TOP;
         obs_x_q     <= SCREEN_W_C;
         obs_y_q     <= OBS_TOP;
         vy_q        <= 6'sd0;
         score_q     <= '0;
         jump_req_q  <= 1'b0;
         jump_btn_q  <= 1'b0;
         game_over_q <= 1'b0;
         running_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         player_x_q  <= PLAYER_X_C;
         player_y_q  <= player_y_d;
         obs_x_q     <= obs_x_d;
         obs_y_q     <= OBS_TOP;
         vy_q        <= vy_d;
         score_q     <= score_d;
         jump_req_q  <= jump_req_d;
         jump_btn_q  <= jump_btn;
         game_over_q <= game_over_d;
         running_q   <= running_d;
      end
   end

   assign player_x  = player_x_q;
   assign player_y  = player_y_q;
   assign obs_x     = obs_x_q;
   assign obs_y     = obs_y_q;
   assign score     = score_q;
   assign game_over = game_over_q;
   assign running   = running_q;

endmodule
